// File: rtl/shift_sequencer_if.sv
// Purpose: request/result bundle between a shift_sequencer and its controller.
// Latency: none, wires only.
// Backpressure: ready gates start; a start seen while ready=0 is dropped.
interface shift_sequencer_if;
  logic        start;
  logic        abort;
  logic        mem;
  logic        imm;
  logic [11:0] shift_operand;
  logic [31:0] rm_value;
  logic        carry_in;
  logic        ready;
  logic        done;
  logic [31:0] val2;
  logic        c_out;

  modport master (
    output start, abort, mem, imm, shift_operand, rm_value, carry_in,
    input  ready, done, val2, c_out
  );

  modport slave (
    input  start, abort, mem, imm, shift_operand, rm_value, carry_in,
    output ready, done, val2, c_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// Purpose: bit-serial barrel-shifter substitute for operand-2 (LSL/LSR/ASR/ROR, rotated imm, mem offset).
// Latency: done in cycle T+n+1 for shift amount n (T+1 when n=0), one bit per cycle.
// Backpressure: ready=0 while shifting; start is ignored then (no queueing), abort cancels.
module shift_sequencer (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] work_q,  work_d;
  logic [1:0]  type_q,  type_d;
  logic [4:0]  count_q, count_d;
  logic        carry_q, carry_d;
  logic [31:0] val2_q,  val2_d;
  logic        c_out_q, c_out_d;

  logic        accept;
  logic [31:0] ld_work;
  logic [1:0]  ld_type;
  logic [4:0]  ld_count;
  logic [31:0] sh_work;
  logic        sh_carry;

  // Operand decode for a newly accepted request; mem mode overrides imm mode.
  always_comb begin
    ld_work  = bus.rm_value;
    ld_type  = bus.shift_operand[6:5];
    ld_count = bus.shift_operand[11:7];
    if (bus.mem) begin
      ld_work  = {{20{bus.shift_operand[11]}}, bus.shift_operand};
      ld_count = 5'd0;
    end else if (bus.imm) begin
      ld_work  = {24'h000000, bus.shift_operand[7:0]};
      ld_type  = T_ROR;
      ld_count = {bus.shift_operand[11:8], 1'b0};
    end
  end

  // One-bit shift of the working value by the latched type; carry is the bit shifted out.
  always_comb begin
    sh_work  = work_q;
    sh_carry = carry_q;
    unique case (type_q)
      T_LSL: begin sh_work = {work_q[30:0], 1'b0};       sh_carry = work_q[31]; end
      T_LSR: begin sh_work = {1'b0, work_q[31:1]};       sh_carry = work_q[0];  end
      T_ASR: begin sh_work = {work_q[31], work_q[31:1]}; sh_carry = work_q[0];  end
      T_ROR: begin sh_work = {work_q[0], work_q[31:1]};  sh_carry = work_q[0];  end
      default: ;
    endcase
  end

  // Abort beats start, so an aborting cycle never accepts.
  assign accept = bus.start && !bus.abort;

  // Next-state and datapath update; val2/c_out only move on the transition into DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    type_d  = type_q;
    count_d = count_q;
    carry_d = carry_q;
    val2_d  = val2_q;
    c_out_d = c_out_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          work_d  = ld_work;
          type_d  = ld_type;
          count_d = ld_count;
          carry_d = bus.carry_in;
          if (ld_count == 5'd0) begin
            // Zero amount: result is the operand untouched, carry passes through.
            state_d = S_DONE;
            val2_d  = ld_work;
            c_out_d = bus.carry_in;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          work_d  = sh_work;
          carry_d = sh_carry;
          count_d = count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_d = S_DONE;
            val2_d  = sh_work;
            c_out_d = sh_carry;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset also clears the published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= 32'h0;
      type_q  <= T_LSL;
      count_q <= 5'd0;
      carry_q <= 1'b0;
      val2_q  <= 32'h0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      type_q  <= type_d;
      count_q <= count_d;
      carry_q <= carry_d;
      val2_q  <= val2_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.ready = (state_q != S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.val2  = val2_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: randomized and directed self-check of shift_sequencer against a whole-shift arithmetic model.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercises ignored starts during SHIFT, abort and back-to-back starts.
module tb_shift_sequencer;

  logic clk;
  logic rst;
  shift_sequencer_if bus_if ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_v   = 32'h0;
  logic        prev_c   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-operation reference: result of shifting by n in one step.
  task automatic model(input logic m, input logic i, input logic [11:0] so, input logic [31:0] rm,
                       input logic ci, output logic [31:0] v, output logic c, output int n);
    logic [31:0]        base;
    logic signed [31:0] sb;
    int                 t;
    if (m) begin
      base = {{20{so[11]}}, so};
      n    = 0;
      t    = 0;
    end else if (i) begin
      base = {24'h0, so[7:0]};
      n    = 2 * int'(so[11:8]);
      t    = 3;
    end else begin
      base = rm;
      n    = int'(so[11:7]);
      t    = int'(so[6:5]);
    end
    v = base;
    c = ci;
    if (n != 0) begin
      case (t)
        0: begin v = base << n; c = base[32-n]; end
        1: begin v = base >> n; c = base[n-1];  end
        2: begin sb = base; v = sb >>> n; c = base[n-1]; end
        default: begin v = (base >> n) | (base << (32 - n)); c = v[31]; end
      endcase
    end
  endtask

  task automatic scramble();
    bus_if.mem           = ($urandom_range(0, 1) != 0);
    bus_if.imm           = ($urandom_range(0, 1) != 0);
    bus_if.shift_operand = 12'($urandom);
    bus_if.rm_value      = $urandom;
    bus_if.carry_in      = ($urandom_range(0, 1) != 0);
  endtask

  task automatic drive_req(input logic m, input logic i, input logic [11:0] so,
                           input logic [31:0] rm, input logic ci);
    bus_if.start         = 1'b1;
    bus_if.abort         = 1'b0;
    bus_if.mem           = m;
    bus_if.imm           = i;
    bus_if.shift_operand = so;
    bus_if.rm_value      = rm;
    bus_if.carry_in      = ci;
  endtask

  // Issues one request from IDLE and follows it to DONE and back to IDLE.
  task automatic run_op(input logic m, input logic i, input logic [11:0] so, input logic [31:0] rm,
                        input logic ci, input bit noise, input bit fixed,
                        input logic [31:0] fv, input logic fc, input int flat);
    logic [31:0] ev;
    logic        ec;
    int          n;
    int          k;
    bit          seen;
    model(m, i, so, rm, ci, ev, ec, n);
    if (fixed) begin
      ev = fv;
      ec = fc;
      n  = flat - 1;
    end
    check_eq("ready_idle", 32'(bus_if.ready), 32'd1);
    drive_req(m, i, so, rm, ci);
    @(negedge clk);
    scramble();
    k    = 1;
    seen = 0;
    while (!seen && k <= 40) begin
      bus_if.start = 1'b0;
      if (bus_if.done) begin
        seen = 1;
      end else begin
        check_eq("ready_shift", 32'(bus_if.ready), 32'd0);
        check_eq("val2_hold", bus_if.val2, prev_v);
        check_eq("cout_hold", 32'(bus_if.c_out), 32'(prev_c));
        if (noise) bus_if.start = ($urandom_range(0, 1) != 0);
        @(negedge clk);
        k++;
      end
    end
    check_eq("latency", 32'(k), 32'(n + 1));
    check_eq("val2", bus_if.val2, ev);
    check_eq("c_out", 32'(bus_if.c_out), 32'(ec));
    check_eq("ready_done", 32'(bus_if.ready), 32'd1);
    prev_v = ev;
    prev_c = ec;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(bus_if.done), 32'd0);
    check_eq("val2_after", bus_if.val2, prev_v);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int j = 0; j < cycles; j++) begin
      if (bus_if.done) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] so;
    logic [31:0] rm;
    logic [31:0] ev;
    logic        ec;
    logic        m;
    logic        i;
    int          n;
    int          cnt;

    rst                  = 1'b1;
    bus_if.start         = 1'b1;
    bus_if.abort         = 1'b1;
    bus_if.mem           = 1'b0;
    bus_if.imm           = 1'b0;
    bus_if.shift_operand = 12'h0;
    bus_if.rm_value      = 32'h0;
    bus_if.carry_in      = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with start/abort held high to show reset priority.
    check_eq("rst_ready", 32'(bus_if.ready), 32'd1);
    check_eq("rst_done",  32'(bus_if.done),  32'd0);
    check_eq("rst_val2",  bus_if.val2,       32'h0);
    check_eq("rst_cout",  32'(bus_if.c_out), 32'd0);
    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-derived results.
    so = {5'd4, 2'b00, 5'd0};
    run_op(1'b0, 1'b0, so, 32'h80000001, 1'b1, 1'b0, 1'b1, 32'h00000010, 1'b0, 5);
    so = {5'd8, 2'b10, 5'd0};
    run_op(1'b0, 1'b0, so, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'hFF800000, 1'b0, 9);
    so = {5'd1, 2'b11, 5'd0};
    run_op(1'b0, 1'b0, so, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 2);
    so = {4'd4, 8'hFF};
    run_op(1'b0, 1'b1, so, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hFF000000, 1'b1, 9);
    so = 12'h800;
    run_op(1'b1, 1'b1, so, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'hFFFFF800, 1'b1, 1);
    so = {5'd0, 2'b11, 5'd0};
    run_op(1'b0, 1'b0, so, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1);

    // Randomized requests, with ignored starts sprinkled into SHIFT.
    for (int it = 0; it < 60; it++) begin
      n  = int'($urandom_range(0, 3));
      m  = (n == 0);
      i  = (n == 1) || (m && ($urandom_range(0, 1) != 0));
      so = 12'($urandom);
      if ($urandom_range(0, 7) == 0) so[11:7] = 5'd0;
      if ($urandom_range(0, 7) == 0) so[11:7] = 5'd31;
      rm = $urandom;
      run_op(m, i, so, rm, ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0),
             1'b0, 32'h0, 1'b0, 0);
    end

    // LSR by 10 aborted at T+3; start at T+2 must be ignored.
    so = {5'd10, 2'b01, 5'd0};
    drive_req(1'b0, 1'b0, so, $urandom, 1'b1);
    @(negedge clk);
    bus_if.start = 1'b0;
    check_eq("abort_t1_ready", 32'(bus_if.ready), 32'd0);
    @(negedge clk);
    check_eq("abort_t2_ready", 32'(bus_if.ready), 32'd0);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b1;
    check_eq("abort_t3_ready", 32'(bus_if.ready), 32'd0);
    @(negedge clk);
    bus_if.abort = 1'b0;
    check_eq("abort_t4_ready", 32'(bus_if.ready), 32'd1);
    check_eq("abort_t4_done",  32'(bus_if.done),  32'd0);
    check_eq("abort_val2",     bus_if.val2,       prev_v);
    check_eq("abort_cout",     32'(bus_if.c_out), 32'(prev_c));
    count_dones(14, cnt);
    check_eq("abort_no_done", 32'(cnt), 32'd0);

    // Abort in IDLE drops a coincident start.
    drive_req(1'b0, 1'b0, 12'h0, $urandom, 1'b1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    count_dones(4, cnt);
    check_eq("idle_abort_no_done", 32'(cnt), 32'd0);
    check_eq("idle_abort_val2", bus_if.val2, prev_v);

    // Back-to-back zero-amount requests, then abort+start in DONE.
    so = 12'($urandom);
    drive_req(1'b1, 1'b0, so, $urandom, 1'b0);
    model(1'b1, 1'b0, so, 32'h0, 1'b0, ev, ec, n);
    @(negedge clk);
    check_eq("b2b_done1", 32'(bus_if.done), 32'd1);
    check_eq("b2b_val1",  bus_if.val2,      ev);
    check_eq("b2b_ready", 32'(bus_if.ready), 32'd1);
    rm = $urandom;
    so = {5'd0, 2'b01, 5'($urandom)};
    drive_req(1'b0, 1'b0, so, rm, 1'b1);
    model(1'b0, 1'b0, so, rm, 1'b1, ev, ec, n);
    @(negedge clk);
    check_eq("b2b_done2", 32'(bus_if.done), 32'd1);
    check_eq("b2b_val2",  bus_if.val2,      ev);
    check_eq("b2b_cout2", 32'(bus_if.c_out), 32'(ec));
    prev_v = ev;
    prev_c = ec;
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    check_eq("done_abort_done",  32'(bus_if.done),  32'd0);
    check_eq("done_abort_ready", 32'(bus_if.ready), 32'd1);
    check_eq("done_abort_val2",  bus_if.val2,       prev_v);

    // Reset in the middle of a long shift.
    so = {5'd20, 2'b00, 5'd0};
    drive_req(1'b0, 1'b0, so, $urandom, 1'b1);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst          = 1'b1;
    bus_if.start = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus_if.start = 1'b0;
    check_eq("midrst_ready", 32'(bus_if.ready), 32'd1);
    check_eq("midrst_done",  32'(bus_if.done),  32'd0);
    check_eq("midrst_val2",  bus_if.val2,       32'h0);
    check_eq("midrst_cout",  32'(bus_if.c_out), 32'd0);
    prev_v = 32'h0;
    prev_c = 1'b0;
    count_dones(25, cnt);
    check_eq("midrst_no_done", 32'(cnt), 32'd0);

    // Normal operation resumes after reset.
    for (int it = 0; it < 5; it++) begin
      so = 12'($urandom);
      run_op(1'b0, 1'b0, so, $urandom, ($urandom_range(0, 1) != 0), 1'b1,
             1'b0, 32'h0, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
